// File: rtl/vga_timing_recovery.sv
// vga_timing_recovery
//   Receive-side timing recovery for a VGA-style raster. Samples a raw
//   hsync/vsync pair, rebuilds the pixel coordinates, qualifies them with a
//   lock FSM and counts lock losses for field diagnostics.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   hsync        horizontal sync in, active-high
//   vsync        vertical sync in, active-high, edges aligned to hcount 0
//   x, y         recovered hcount / vcount of the most recent sample
//   de           data enable: locked & x < HACTIVE & y < VACTIVE
//   frame_start  one-cycle pulse at locked & x == 0 & y == 0
//   locked       lock FSM is in LOCKED
//   lost_lock    one-cycle pulse on a LOCKED -> LINE_SYNC drop
//   err_cnt      saturating count of lock losses
module vga_timing_recovery #(
  parameter int unsigned HTOTAL      = 1344,
  parameter int unsigned HSYNC_START = 1048,
  parameter int unsigned HSYNC_END   = 1184,
  parameter int unsigned VTOTAL      = 806,
  parameter int unsigned VSYNC_START = 771,
  parameter int unsigned VSYNC_END   = 777,
  parameter int unsigned HACTIVE     = 1024,
  parameter int unsigned VACTIVE     = 768,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        de,
  output logic        frame_start,
  output logic        locked,
  output logic        lost_lock,
  output logic [7:0]  err_cnt
);

  localparam int unsigned CW = 11;
  localparam int unsigned EW = 8;
  localparam int unsigned GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    SEARCH     = 2'd0,
    LINE_SYNC  = 2'd1,
    FRAME_SYNC = 2'd2,
    LOCKED     = 2'd3
  } state_e;

  logic          hs_q, hs_qq, vs_q, vs_qq;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [GW-1:0] good_inc;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic          de_q, de_d;
  logic          frame_start_q, frame_start_d;
  logic          locked_q, locked_d;
  logic          lost_lock_q, lost_lock_d;

  logic hrise, hfall, vrise, vfall;
  logic h_pos_err, h_wid_err, v_pos_err, v_wid_err;
  logic any_err;
  logic h_wrap;

  // Two-stage sync pipeline: *_q is the sample h_cnt/v_cnt describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= 1'b0;
      hs_qq <= 1'b0;
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
    end else begin
      hs_q  <= hsync;
      hs_qq <= hs_q;
      vs_q  <= vsync;
      vs_qq <= vs_q;
    end
  end

  // Edge detection and timing checks against the expected raster.
  always_comb begin
    hrise     = hs_q & ~hs_qq;
    hfall     = ~hs_q & hs_qq;
    vrise     = vs_q & ~vs_qq;
    vfall     = ~vs_q & vs_qq;
    h_pos_err = hrise & (h_cnt_q != CW'(HSYNC_START));
    h_wid_err = hfall & (h_cnt_q != CW'(HSYNC_END));
    v_pos_err = vrise & ((v_cnt_q != CW'(VSYNC_START)) | (h_cnt_q != '0));
    v_wid_err = vfall & ((v_cnt_q != CW'(VSYNC_END)) | (h_cnt_q != '0));
    any_err   = h_pos_err | h_wid_err | v_pos_err | v_wid_err;
  end

  // Free-running counters, realigned on sync rises. An hrise preempts the
  // wrap, so the line count only advances on a genuine free-run wrap.
  always_comb begin
    h_wrap = ~hrise & (h_cnt_q == CW'(HTOTAL - 1));

    if (hrise) begin
      h_cnt_d = CW'(HSYNC_START + 1);
    end else if (h_wrap) begin
      h_cnt_d = '0;
    end else begin
      h_cnt_d = h_cnt_q + CW'(1);
    end

    if (vrise) begin
      v_cnt_d = CW'(VSYNC_START);
    end else if (h_wrap) begin
      v_cnt_d = (v_cnt_q == CW'(VTOTAL - 1)) ? '0 : v_cnt_q + CW'(1);
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  // Lock FSM: next state, clean-frame counter and loss counter.
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    err_cnt_d   = err_cnt_q;
    lost_lock_d = 1'b0;
    good_inc    = good_q + GW'(1);

    case (state_q)
      SEARCH: begin
        if (hrise) begin
          state_d = LINE_SYNC;
        end
      end
      LINE_SYNC: begin
        if (vrise) begin
          state_d = FRAME_SYNC;
          good_d  = '0;
        end
      end
      FRAME_SYNC: begin
        // Any error bounces straight back, so reaching a vrise here means
        // the whole preceding frame was clean.
        if (any_err) begin
          state_d = LINE_SYNC;
        end else if (vrise) begin
          good_d = good_inc;
          if (32'(good_inc) >= LOCK_FRAMES) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_d     = LINE_SYNC;
          lost_lock_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + EW'(1);
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // Registered qualifiers, computed from next-state values so they line up
  // with the x/y registered on the same edge.
  always_comb begin
    locked_d      = (state_d == LOCKED);
    de_d          = locked_d & (h_cnt_d < CW'(HACTIVE)) & (v_cnt_d < CW'(VACTIVE));
    frame_start_d = locked_d & (h_cnt_d == '0) & (v_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      state_q       <= SEARCH;
      good_q        <= '0;
      err_cnt_q     <= '0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      lost_lock_q   <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      state_q       <= state_d;
      good_q        <= good_d;
      err_cnt_q     <= err_cnt_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      lost_lock_q   <= lost_lock_d;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign de          = de_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign lost_lock   = lost_lock_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Testbench for vga_timing_recovery using a shrunken raster so many frames
// fit in a short run. A bench-side generator drives sync with injectable
// faults; a behavioural model predicts every output cycle by cycle.
module tb_vga_timing_recovery;

  localparam int HT    = 8;
  localparam int HS_S  = 5;
  localparam int HS_E  = 7;
  localparam int HA    = 4;
  localparam int VT    = 6;
  localparam int VS_S  = 3;
  localparam int VS_E  = 5;
  localparam int VA    = 2;
  localparam int LOCK  = 2;
  localparam int FRAME = HT * VT;
  // Progress ladder: 0 searching, 1 line found, 2..LOCK+1 counting clean
  // frames, LOCK+2 locked.
  localparam int LOCKED_LVL = LOCK + 2;

  logic        clk, rst_n, hsync, vsync;
  logic [10:0] x, y;
  logic        de, frame_start, locked, lost_lock;
  logic [7:0]  err_cnt;
  logic [33:0] dut_bus;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int gen_h, gen_v, early_arm, early_now, narrow, vshift, vrise_cnt;
  bit gen_vs_prev;

  int m_h, m_v, m_level, m_errc;
  bit m_p1h, m_p2h, m_p1v, m_p2v, m_lost;

  vga_timing_recovery #(
    .HTOTAL(HT), .HSYNC_START(HS_S), .HSYNC_END(HS_E),
    .VTOTAL(VT), .VSYNC_START(VS_S), .VSYNC_END(VS_E),
    .HACTIVE(HA), .VACTIVE(VA), .LOCK_FRAMES(LOCK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .de(de), .frame_start(frame_start),
    .locked(locked), .lost_lock(lost_lock), .err_cnt(err_cnt)
  );

  assign dut_bus = {x, y, de, frame_start, locked, lost_lock, err_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] exp_bus();
    bit lk;
    lk = (m_level == LOCKED_LVL);
    return {11'(m_h), 11'(m_v),
            1'(lk && m_h < HA && m_v < VA),
            1'(lk && m_h == 0 && m_v == 0),
            lk, m_lost, 8'(m_errc)};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_level = 0; m_errc = 0; m_lost = 0;
    m_p1h = 0; m_p2h = 0; m_p1v = 0; m_p2v = 0;
  endtask

  // Applies one new sync sample: judges the edge formed by the two previous
  // samples, then positions the new sample on the raster.
  task automatic model_step(input bit s_hs, input bit s_vs);
    bit hr, hf, vr, vf, err;
    int nh, nv;
    hr  = m_p1h && !m_p2h;
    hf  = !m_p1h && m_p2h;
    vr  = m_p1v && !m_p2v;
    vf  = !m_p1v && m_p2v;
    err = (hr && m_h != HS_S) || (hf && m_h != HS_E) ||
          (vr && (m_v != VS_S || m_h != 0)) || (vf && (m_v != VS_E || m_h != 0));
    m_lost = 0;
    if (m_level == 0) begin
      if (hr) m_level = 1;
    end else if (m_level == 1) begin
      if (vr) m_level = 2;
    end else if (m_level < LOCKED_LVL) begin
      if (err) m_level = 1;
      else if (vr) m_level = m_level + 1;
    end else if (err) begin
      m_level = 1;
      m_lost  = 1;
      if (m_errc < 255) m_errc = m_errc + 1;
    end
    nh = hr ? HS_S + 1 : (m_h + 1) % HT;
    if (vr) nv = VS_S;
    else if (!hr && m_h == HT - 1) nv = (m_v + 1) % VT;
    else nv = m_v;
    m_h = nh; m_v = nv;
    m_p2h = m_p1h; m_p1h = s_hs;
    m_p2v = m_p1v; m_p1v = s_vs;
  endtask

  task automatic gen_advance();
    gen_h = gen_h + 1;
    if (gen_h == HT) begin
      gen_h = 0;
      gen_v = (gen_v + 1) % VT;
    end
  endtask

  // One pixel clock: drive the generator sample, clock it, advance the model.
  task automatic gen_cycle();
    bit hs, vs;
    if (gen_h == 0) begin
      early_now = early_arm;
      early_arm = 0;
    end
    hs = (gen_h >= HS_S - early_now) && (gen_h < HS_E - narrow);
    vs = (gen_v >= VS_S + vshift) && (gen_v < VS_E + vshift);
    hsync = hs;
    vsync = vs;
    if (vs && !gen_vs_prev) vrise_cnt = vrise_cnt + 1;
    gen_vs_prev = vs;
    @(posedge clk);
    model_step(hs, vs);
    gen_advance();
    #1;
    cyc = cyc + 1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_bus !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", dut_bus, 34'd0);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int lock_vr = -1;
    int de_n = 0, fs_n = 0, fs_t1 = -1, fs_t2 = -1;
    for (int i = 0; i < 5 * FRAME; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL nominal cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
      if (locked === 1'b1 && lock_vr < 0) lock_vr = vrise_cnt;
    end
    checks++;
    if (lock_vr !== 3) begin
      errors++;
      $display("FAIL lock_after_vrises got=%0d exp=3", lock_vr);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL nominal_run cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
      if (de === 1'b1) de_n++;
      if (frame_start === 1'b1) begin
        fs_n++;
        if (fs_t1 < 0) fs_t1 = i;
        else fs_t2 = i;
      end
    end
    checks++;
    if (de_n !== 2 * HA * VA) begin
      errors++;
      $display("FAIL de_per_frame got=%0d exp=%0d", de_n, 2 * HA * VA);
    end
    checks++;
    if (fs_n !== 2) begin
      errors++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_n);
    end
    checks++;
    if (fs_t2 - fs_t1 !== FRAME) begin
      errors++;
      $display("FAIL frame_start_period got=%0d exp=%0d", fs_t2 - fs_t1, FRAME);
    end
  endtask

  task automatic test_hsync_early();
    bit seen = 0;
    int pre;
    pre = int'($urandom_range(0, FRAME - 1));
    for (int i = 0; i < pre; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL early_pre cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
    end
    early_arm = 1;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL early cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
      if (lost_lock === 1'b1) begin
        seen = 1;
        checks++;
        if (err_cnt !== 8'd1) begin
          errors++;
          $display("FAIL early_err_cnt got=%0d exp=1", err_cnt);
        end
        checks++;
        if (x !== 11'(HS_S + 1)) begin
          errors++;
          $display("FAIL early_realign_x got=%0d exp=%0d", x, HS_S + 1);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL early_lost_lock got=none exp=pulse");
    end
    for (int i = 0; i < 4 * FRAME; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL early_relock cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL early_relocked got=%b exp=1", locked);
    end
  endtask

  task automatic test_hsync_narrow();
    int hi = 0;
    narrow = 1;
    for (int i = 0; i < 5 * FRAME; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL narrow cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
      if (i >= FRAME && (locked === 1'b1 || de === 1'b1)) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL narrow_no_lock got=%0d exp=0", hi);
    end
    narrow = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL narrow_relock cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL narrow_relocked got=%b exp=1", locked);
    end
  endtask

  task automatic test_vsync_late();
    bit seen = 0;
    for (int i = 0; i < FRAME && !(gen_h == 0 && gen_v == 0); i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL vlate_align cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
    end
    vshift = 1;
    for (int i = 0; i < FRAME; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL vlate cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
      if (lost_lock === 1'b1 && !seen) begin
        seen = 1;
        checks++;
        if (y !== 11'(VS_S)) begin
          errors++;
          $display("FAIL vlate_reload_y got=%0d exp=%0d", y, VS_S);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL vlate_lost_lock got=none exp=pulse");
    end
    vshift = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL vlate_relock cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL vlate_relocked got=%b exp=1", locked);
    end
  endtask

  task automatic test_async_reset();
    int pre, off;
    pre = int'($urandom_range(1, FRAME));
    off = int'($urandom_range(1, 7));
    for (int i = 0; i < pre; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL areset_pre cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL areset_locked_before got=%b exp=1", locked);
    end
    #(off);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_bus !== 34'd0) begin
      errors++;
      $display("FAIL areset_immediate got=%h exp=%h", dut_bus, 34'd0);
    end
    @(posedge clk);
    #1;
    gen_advance();
    model_reset();
    checks++;
    if (dut_bus !== 34'd0) begin
      errors++;
      $display("FAIL areset_held got=%h exp=%h", dut_bus, 34'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5 * FRAME; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL areset_relock cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL areset_relocked got=%b exp=1", locked);
    end
  endtask

  task automatic test_err_saturation();
    int losses = 0;
    int hold;
    hold = int'($urandom_range(0, 15));
    for (int i = 0; i < 60000 && losses < 300; i++) begin
      gen_cycle();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL saturate cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
      if (m_lost) begin
        losses++;
        hold = int'($urandom_range(0, 15));
      end
      if (m_level == LOCKED_LVL && early_arm == 0 && early_now == 0) begin
        if (hold == 0) early_arm = 1;
        else hold--;
      end
    end
    checks++;
    if (losses !== 300) begin
      errors++;
      $display("FAIL saturate_losses got=%0d exp=300", losses);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturate_err_cnt got=%0d exp=255", err_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0;
    gen_h = 0; gen_v = 0; early_arm = 0; early_now = 0;
    narrow = 0; vshift = 0; vrise_cnt = 0; gen_vs_prev = 0;
    model_reset();
    test_reset();
    test_nominal();
    test_hsync_early();
    test_hsync_narrow();
    test_vsync_late();
    test_async_reset();
    test_err_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
